// File: rtl/noc_pkg.sv
// Shared definitions for the mesh router: route codes, flit field positions and flit width.
// The route codes are the crossbar output-port numbers used by every input stage.
package noc_pkg;

    localparam int DATA_W = 8;

    localparam int DST_X_MSB = 3;
    localparam int DST_X_LSB = 2;
    localparam int DST_Y_MSB = 1;
    localparam int DST_Y_LSB = 0;

    typedef enum logic [2:0] {
        ROUTE_L = 3'd0,
        ROUTE_N = 3'd1,
        ROUTE_E = 3'd2,
        ROUTE_S = 3'd3,
        ROUTE_W = 3'd4
    } route_e;

endpackage

// File: rtl/noc_xy_route.sv
// Dimension-ordered (X then Y) route selection for one flit at this router's coordinates.
// Purely combinational so every input port can share the same decision logic.
module noc_xy_route
    import noc_pkg::*;
#(
    parameter int FLIT_W = noc_pkg::DATA_W,
    parameter int ADDR_W = 2
) (
    input  logic [FLIT_W-1:0] flit,
    input  logic [ADDR_W-1:0] X_address,
    input  logic [ADDR_W-1:0] Y_address,
    output logic [2:0]        r
);

    logic [ADDR_W-1:0] dst_x;
    logic [ADDR_W-1:0] dst_y;
    logic              unused_payload;

    // Payload bits do not affect routing.
    assign unused_payload = ^flit[FLIT_W-1:DST_X_MSB+1];

    always_comb begin
        dst_x = flit[DST_X_LSB +: ADDR_W];
        dst_y = flit[DST_Y_LSB +: ADDR_W];
        r     = ROUTE_L;
        if (dst_x > X_address) begin
            r = ROUTE_E;
        end else if (dst_x < X_address) begin
            r = ROUTE_W;
        end else if (dst_y > Y_address) begin
            r = ROUTE_S;
        end else if (dst_y < Y_address) begin
            r = ROUTE_N;
        end
    end

endmodule

// File: rtl/noc_input_buffer.sv
// Per-port router input stage: FWFT flit FIFO, head-flit XY route, credit return and sticky overflow.
// Handshake: a flit enters when val_in is high and (!full or the head pops that cycle); the head pops when grant && val_out; each pop returns one credit on ret_in the following cycle.
module noc_input_buffer
    import noc_pkg::*;
#(
    parameter int DATA_W = noc_pkg::DATA_W,
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [ADDR_W-1:0]          X_address,
    input  logic [ADDR_W-1:0]          Y_address,
    input  logic [DATA_W-1:0]          Data_in,
    input  logic                       val_in,
    output logic                       ret_in,
    input  logic                       grant,
    output logic [DATA_W-1:0]          Data_out,
    output logic                       val_out,
    output logic [2:0]                 r_out,
    output logic                       full,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       overflow
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              ret_q, ret_d;
    logic              ovf_q, ovf_d;

    logic              empty;
    logic              is_full;
    logic              pop;
    logic              wr_en;
    logic [DATA_W-1:0] head;
    logic [2:0]        head_route;

    // Count, not pointer equality, separates full from empty.
    always_comb begin
        empty    = (count_q == '0);
        is_full  = (count_q == CNT_W'(DEPTH));
        pop      = grant && !empty;
        wr_en    = val_in && (!is_full || pop);
        wr_ptr_d = wr_en ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        count_d  = count_q;
        if (wr_en && !pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (pop && !wr_en) begin
            count_d = count_q - CNT_W'(1);
        end
        ret_d    = pop;
        ovf_d    = ovf_q || (val_in && is_full && !pop);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ret_q    <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ret_q    <= ret_d;
            ovf_q    <= ovf_d;
        end
    end

    // Storage is deliberately left unreset; count gates every read.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= Data_in;
        end
    end

    assign head = mem_q[rd_ptr_q];

    noc_xy_route #(
        .FLIT_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_route (
        .flit      (head),
        .X_address (X_address),
        .Y_address (Y_address),
        .r         (head_route)
    );

    assign Data_out = empty ? '0 : head;
    assign r_out    = empty ? 3'(ROUTE_L) : head_route;
    assign val_out  = !empty;
    assign full     = is_full;
    assign count    = count_q;
    assign ret_in   = ret_q;
    assign overflow = ovf_q;

endmodule

// File: tb/tb_noc_input_buffer.sv
// Directed bench for the router input buffer at coordinates (1,1).
// Inputs change 1 ns after a rising edge; outputs are sampled at that point as well.
module tb_noc_input_buffer;

    logic       clk;
    logic       rst;
    logic [1:0] X_address;
    logic [1:0] Y_address;
    logic [7:0] Data_in;
    logic       val_in;
    logic       ret_in;
    logic       grant;
    logic [7:0] Data_out;
    logic       val_out;
    logic [2:0] r_out;
    logic       full;
    logic [2:0] count;
    logic       overflow;

    int errors = 0;
    int checks = 0;

    noc_input_buffer #(
        .DATA_W (8),
        .DEPTH  (4),
        .ADDR_W (2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .X_address (X_address),
        .Y_address (Y_address),
        .Data_in   (Data_in),
        .val_in    (val_in),
        .ret_in    (ret_in),
        .grant     (grant),
        .Data_out  (Data_out),
        .val_out   (val_out),
        .r_out     (r_out),
        .full      (full),
        .count     (count),
        .overflow  (overflow)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        val_in  = 1'b0;
        grant   = 1'b0;
        Data_in = 8'h00;
        rst     = 1'b1;
        step();
        rst     = 1'b0;
        step();
    endtask

    task automatic write_flit(input logic [7:0] f);
        Data_in = f;
        val_in  = 1'b1;
        step();
        val_in  = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        for (int i = 0; i < 4; i++) write_flit(8'h30 + 8'(i));
        grant = 1'b1;
        step();
        grant = 1'b0;
        checks++;
        if (count !== 3'd3 || ret_in !== 1'b1) begin
            errors++;
            $display("FAIL reset_pre: count=%0d ret_in=%b required count=3 ret_in=1", count, ret_in);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (val_out !== 1'b0 || count !== 3'd0 || full !== 1'b0 || ret_in !== 1'b0 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL reset_async: val_out=%b count=%0d full=%b ret_in=%b overflow=%b required all 0",
                     val_out, count, full, ret_in, overflow);
        end
        checks++;
        if (Data_out !== 8'h00 || r_out !== 3'd0) begin
            errors++;
            $display("FAIL reset_outputs: Data_out=%h r_out=%0d required 00 and 0", Data_out, r_out);
        end
        step();
        rst = 1'b0;
        step();
    endtask

    task automatic test_routing();
        logic [7:0] flits [6];
        logic [2:0] routes[6];
        int         pulses;
        flits  = '{8'h0B, 8'h01, 8'h06, 8'h04, 8'h05, 8'h07};
        routes = '{3'd2,  3'd4,  3'd3,  3'd1,  3'd0,  3'd3};
        pulses = 0;
        apply_reset();
        for (int i = 0; i < 6; i++) begin
            write_flit(flits[i]);
            checks++;
            if (val_out !== 1'b1 || Data_out !== flits[i] || r_out !== routes[i]) begin
                errors++;
                $display("FAIL route_%0d: val_out=%b Data_out=%h r_out=%0d required 1 %h %0d",
                         i, val_out, Data_out, r_out, flits[i], routes[i]);
            end
            grant = 1'b1;
            step();
            grant = 1'b0;
            if (ret_in === 1'b1) pulses++;
            checks++;
            if (val_out !== 1'b0 || count !== 3'd0) begin
                errors++;
                $display("FAIL route_pop_%0d: val_out=%b count=%0d required 0 0", i, val_out, count);
            end
            step();
            checks++;
            if (ret_in !== 1'b0) begin
                errors++;
                $display("FAIL route_ret_fall_%0d: ret_in=%b required 0", i, ret_in);
            end
        end
        checks++;
        if (pulses != 6) begin
            errors++;
            $display("FAIL route_credits: pulses=%0d required 6", pulses);
        end
    endtask

    task automatic test_fill();
        apply_reset();
        for (int i = 0; i < 4; i++) write_flit(8'hA0 + 8'(i));
        checks++;
        if (full !== 1'b1 || count !== 3'd4 || overflow !== 1'b0 || Data_out !== 8'hA0) begin
            errors++;
            $display("FAIL fill_full: full=%b count=%0d overflow=%b Data_out=%h required 1 4 0 a0",
                     full, count, overflow, Data_out);
        end
        write_flit(8'hA4);
        checks++;
        if (overflow !== 1'b1 || count !== 3'd4 || full !== 1'b1) begin
            errors++;
            $display("FAIL fill_overflow: overflow=%b count=%0d full=%b required 1 4 1", overflow, count, full);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (Data_out !== 8'hA0 + 8'(i)) begin
                errors++;
                $display("FAIL fill_drain_%0d: Data_out=%h required %h", i, Data_out, 8'hA0 + 8'(i));
            end
            grant = 1'b1;
            step();
        end
        grant = 1'b0;
        checks++;
        if (val_out !== 1'b0 || overflow !== 1'b1) begin
            errors++;
            $display("FAIL fill_after: val_out=%b overflow=%b required 0 1", val_out, overflow);
        end
    endtask

    task automatic test_full_simul();
        apply_reset();
        for (int i = 0; i < 4; i++) write_flit(8'hB0 + 8'(i));
        Data_in = 8'hB4;
        val_in  = 1'b1;
        grant   = 1'b1;
        step();
        val_in  = 1'b0;
        grant   = 1'b0;
        checks++;
        if (count !== 3'd4 || full !== 1'b1 || ret_in !== 1'b1 || overflow !== 1'b0 || Data_out !== 8'hB1) begin
            errors++;
            $display("FAIL full_simul: count=%0d full=%b ret_in=%b overflow=%b Data_out=%h required 4 1 1 0 b1",
                     count, full, ret_in, overflow, Data_out);
        end
        for (int i = 1; i < 5; i++) begin
            checks++;
            if (Data_out !== 8'hB0 + 8'(i)) begin
                errors++;
                $display("FAIL full_simul_drain_%0d: Data_out=%h required %h", i, Data_out, 8'hB0 + 8'(i));
            end
            grant = 1'b1;
            step();
        end
        grant = 1'b0;
        checks++;
        if (val_out !== 1'b0 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL full_simul_end: val_out=%b overflow=%b required 0 0", val_out, overflow);
        end
    endtask

    task automatic test_wrap();
        logic [7:0] exp_q[$];
        logic [7:0] next_flit;
        int         cyc;
        logic       do_pop;
        logic       do_wr;
        apply_reset();
        next_flit = 8'h10;
        cyc = 0;
        while ((next_flit != 8'h1A || exp_q.size() != 0) && cyc < 100) begin
            do_pop = (cyc % 2 == 1) && (exp_q.size() != 0);
            do_wr  = (next_flit != 8'h1A) && (exp_q.size() < 4 || do_pop);
            grant  = (cyc % 2 == 1);
            val_in = do_wr;
            Data_in = next_flit;
            if (do_pop) begin
                checks++;
                if (Data_out !== exp_q[0]) begin
                    errors++;
                    $display("FAIL wrap_order: Data_out=%h required %h", Data_out, exp_q[0]);
                end
                void'(exp_q.pop_front());
            end
            if (do_wr) begin
                exp_q.push_back(next_flit);
                next_flit = next_flit + 8'h01;
            end
            step();
            checks++;
            if (count !== 3'(exp_q.size()) || count > 3'd4 || overflow !== 1'b0) begin
                errors++;
                $display("FAIL wrap_count: count=%0d overflow=%b required %0d 0", count, overflow, exp_q.size());
            end
            cyc++;
        end
        val_in = 1'b0;
        grant  = 1'b0;
        checks++;
        if (cyc >= 100 || val_out !== 1'b0) begin
            errors++;
            $display("FAIL wrap_done: cycles=%0d val_out=%b required <100 0", cyc, val_out);
        end
    endtask

    task automatic test_empty_grant();
        apply_reset();
        grant = 1'b1;
        step();
        step();
        checks++;
        if (ret_in !== 1'b0 || val_out !== 1'b0 || count !== 3'd0) begin
            errors++;
            $display("FAIL empty_grant: ret_in=%b val_out=%b count=%0d required 0 0 0", ret_in, val_out, count);
        end
        grant = 1'b0;
        write_flit(8'h2F);
        checks++;
        if (val_out !== 1'b1 || Data_out !== 8'h2F || r_out !== 3'd2 || count !== 3'd1) begin
            errors++;
            $display("FAIL empty_then_write: val_out=%b Data_out=%h r_out=%0d count=%0d required 1 2f 2 1",
                     val_out, Data_out, r_out, count);
        end
        grant = 1'b1;
        step();
        grant = 1'b0;
        checks++;
        if (ret_in !== 1'b1 || val_out !== 1'b0) begin
            errors++;
            $display("FAIL empty_final_pop: ret_in=%b val_out=%b required 1 0", ret_in, val_out);
        end
    endtask

    initial begin
        rst       = 1'b1;
        X_address = 2'd1;
        Y_address = 2'd1;
        Data_in   = 8'h00;
        val_in    = 1'b0;
        grant     = 1'b0;
        #12;
        test_reset();
        test_routing();
        test_fill();
        test_full_simul();
        test_wrap();
        test_empty_grant();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
